// File: rtl/tlb_flush_ctrl.sv
// -----------------------------------------------------------------------------
// tlb_flush_ctrl
//
// Sequences SFENCE.VMA-style flush requests from the commit/CSR stage into the
// shared flush port of the Sv32 ITLB/DTLB pair. Requests are buffered in a
// small FIFO. While anything is pending, new TLB lookups are blocked. The
// controller then waits for the page-table walker to drain and issues a
// single-cycle flush strobe to both TLBs.
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-high reset
//   req_valid_i/req_ready_o   request handshake (accepted on valid && ready)
//   req_vaddr_i, req_asid_i   flush operands (rs1 / rs2)
//   req_vaddr_en_i            rs1 != x0 : qualify the flush by vaddr
//   req_asid_en_i             rs2 != x0 : qualify the flush by ASID
//   ptw_busy_i                page-table walk in flight
//   lu_block_o                suppress new ITLB/DTLB lookups
//   flush_itlb_o/flush_dtlb_o one-cycle flush strobes
//   vaddr_/asid_to_be_flushed_o, flush_by_vaddr_o, flush_by_asid_o
//                             operands of the flush, valid only with the strobe
//   done_o                    one-cycle pulse per completed flush
//   pending_o                 FIFO non-empty or sequencer busy
// -----------------------------------------------------------------------------
module tlb_flush_ctrl #(
    parameter int unsigned ASID_WIDTH = 9,
    parameter int unsigned VLEN       = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [VLEN-1:0]       req_vaddr_i,
    input  logic [ASID_WIDTH-1:0] req_asid_i,
    input  logic                  req_vaddr_en_i,
    input  logic                  req_asid_en_i,
    input  logic                  ptw_busy_i,
    output logic                  lu_block_o,
    output logic                  flush_itlb_o,
    output logic                  flush_dtlb_o,
    output logic [VLEN-1:0]       vaddr_to_be_flushed_o,
    output logic [ASID_WIDTH-1:0] asid_to_be_flushed_o,
    output logic                  flush_by_vaddr_o,
    output logic                  flush_by_asid_o,
    output logic                  done_o,
    output logic                  pending_o
);

    // FIFO_DEPTH is a power of two, so the pointers wrap by plain overflow.
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [VLEN-1:0]       vaddr;
        logic [ASID_WIDTH-1:0] asid;
        logic                  vaddr_en;
        logic                  asid_en;
    } flush_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLOCK,
        ST_FLUSH,
        ST_DONE
    } state_e;

    // -------------------------------------------------------------------------
    // Request FIFO
    // -------------------------------------------------------------------------
    flush_req_t             fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    state_e                 state_q, state_d;

    flush_req_t             req_in;
    flush_req_t             head;
    logic                   full, empty;
    logic                   push, pop;
    logic                   flush_all;

    assign req_in = '{vaddr:    req_vaddr_i,
                      asid:     req_asid_i,
                      vaddr_en: req_vaddr_en_i,
                      asid_en:  req_asid_en_i};

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign head  = fifo_q[rd_ptr_q];

    // Ready depends only on registered occupancy: a pop in the same cycle does
    // not open a slot for the requester until the next cycle.
    assign push  = req_valid_i & ~full;
    assign pop   = (state_q == ST_FLUSH);

    // A flush-all at the head subsumes every other queued entry, so the whole
    // FIFO is dropped in the same cycle instead of flushing them one by one.
    assign flush_all = pop & ~head.vaddr_en & ~head.asid_en;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (flush_all) begin
            // Everything already stored is discarded; a request arriving in
            // this very cycle lands at wr_ptr_q and becomes the new head.
            rd_ptr_d = wr_ptr_q;
            count_d  = push ? CNT_W'(1) : '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Storage is not reset: discarding on reset is done through the pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= req_in;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Flush sequencer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d               = state_q;
        lu_block_o            = 1'b0;
        flush_itlb_o          = 1'b0;
        flush_dtlb_o          = 1'b0;
        vaddr_to_be_flushed_o = '0;
        asid_to_be_flushed_o  = '0;
        flush_by_vaddr_o      = 1'b0;
        flush_by_asid_o       = 1'b0;
        done_o                = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Leave IDLE on the same edge that writes the first entry so
                // lookups are blocked from the cycle after acceptance.
                if (!empty || push) begin
                    state_d = ST_BLOCK;
                end
            end

            ST_BLOCK: begin
                lu_block_o = 1'b1;
                // Any walk still in flight may refill the TLB with a stale
                // translation, so hold until the walker is idle.
                if (!ptw_busy_i) begin
                    state_d = ST_FLUSH;
                end
            end

            ST_FLUSH: begin
                lu_block_o            = 1'b1;
                flush_itlb_o          = 1'b1;
                flush_dtlb_o          = 1'b1;
                vaddr_to_be_flushed_o = head.vaddr;
                asid_to_be_flushed_o  = head.asid;
                flush_by_vaddr_o      = head.vaddr_en;
                flush_by_asid_o       = head.asid_en;
                state_d               = ST_DONE;
            end

            ST_DONE: begin
                done_o     = 1'b1;
                // Keep lookups blocked across back-to-back flushes.
                lu_block_o = !empty;
                state_d    = empty ? ST_IDLE : ST_BLOCK;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready_o = !full;
    assign pending_o   = !empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_tlb_flush_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tlb_flush_ctrl
//
// Directed scenarios followed by a randomized run. Every cycle the DUT outputs
// are compared against a queue-based reference model of the flush rules.
// -----------------------------------------------------------------------------
module tb_tlb_flush_ctrl;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [31:0] vaddr;
        logic [8:0]  asid;
        logic        ven;
        logic        aen;
    } ent_t;

    // Phases of one flush, as seen from outside.
    localparam int P_IDLE  = 0;
    localparam int P_BLOCK = 1;
    localparam int P_FLUSH = 2;
    localparam int P_DONE  = 3;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_vaddr = '0;
    logic [8:0]  req_asid = '0;
    logic        req_ven = 1'b0;
    logic        req_aen = 1'b0;
    logic        ptw_busy = 1'b0;
    logic        lu_block_o;
    logic        flush_itlb_o;
    logic        flush_dtlb_o;
    logic [31:0] vaddr_to_be_flushed_o;
    logic [8:0]  asid_to_be_flushed_o;
    logic        flush_by_vaddr_o;
    logic        flush_by_asid_o;
    logic        done_o;
    logic        pending_o;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_done   = 0;

    ent_t        m_q[$];
    int          m_ph = P_IDLE;

    logic [31:0] s_vaddr[$];
    logic [1:0]  s_qual[$];
    int          s_cyc[$];

    tlb_flush_ctrl #(
        .ASID_WIDTH (9),
        .VLEN       (32),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .req_valid_i           (req_valid),
        .req_ready_o           (req_ready_o),
        .req_vaddr_i           (req_vaddr),
        .req_asid_i            (req_asid),
        .req_vaddr_en_i        (req_ven),
        .req_asid_en_i         (req_aen),
        .ptw_busy_i            (ptw_busy),
        .lu_block_o            (lu_block_o),
        .flush_itlb_o          (flush_itlb_o),
        .flush_dtlb_o          (flush_dtlb_o),
        .vaddr_to_be_flushed_o (vaddr_to_be_flushed_o),
        .asid_to_be_flushed_o  (asid_to_be_flushed_o),
        .flush_by_vaddr_o      (flush_by_vaddr_o),
        .flush_by_asid_o       (flush_by_asid_o),
        .done_o                (done_o),
        .pending_o             (pending_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: advance by one clock edge using the inputs held
    // during the cycle that just ended.
    task automatic model_step();
        bit   acc;
        ent_t e;
        ent_t h;
        acc = req_valid && (m_q.size() < DEPTH);
        e   = '{vaddr: req_vaddr, asid: req_asid, ven: req_ven, aen: req_aen};
        case (m_ph)
            P_IDLE:  if (m_q.size() != 0 || acc) m_ph = P_BLOCK;
            P_BLOCK: if (!ptw_busy) m_ph = P_FLUSH;
            P_FLUSH: begin
                h = m_q.pop_front();
                if (!h.ven && !h.aen) m_q.delete();
                m_ph = P_DONE;
            end
            default: m_ph = (m_q.size() != 0) ? P_BLOCK : P_IDLE;
        endcase
        if (acc) m_q.push_back(e);
    endtask

    task automatic check_all();
        bit   fl;
        bit   blk;
        ent_t h;
        fl  = (m_ph == P_FLUSH);
        h   = (fl && m_q.size() != 0) ? m_q[0] : '0;
        blk = (m_ph == P_BLOCK) || fl || (m_ph == P_DONE && m_q.size() != 0);
        chk("req_ready",  64'(req_ready_o),           64'(m_q.size() < DEPTH));
        chk("pending",    64'(pending_o),             64'(m_q.size() != 0 || m_ph != P_IDLE));
        chk("lu_block",   64'(lu_block_o),            64'(blk));
        chk("flush_itlb", 64'(flush_itlb_o),          64'(fl));
        chk("flush_dtlb", 64'(flush_dtlb_o),          64'(fl));
        chk("done",       64'(done_o),                64'(m_ph == P_DONE));
        chk("vaddr",      64'(vaddr_to_be_flushed_o), 64'(h.vaddr));
        chk("asid",       64'(asid_to_be_flushed_o),  64'(h.asid));
        chk("by_vaddr",   64'(flush_by_vaddr_o),      64'(h.ven));
        chk("by_asid",    64'(flush_by_asid_o),       64'(h.aen));
    endtask

    task automatic cycle();
        @(posedge clk_i);
        model_step();
        cyc++;
        #1;
        check_all();
        if (flush_itlb_o) begin
            s_vaddr.push_back(vaddr_to_be_flushed_o);
            s_qual.push_back({flush_by_vaddr_o, flush_by_asid_o});
            s_cyc.push_back(cyc);
        end
        if (done_o) n_done++;
    endtask

    task automatic set_req(input logic [31:0] va, input logic [8:0] as, input logic ve, input logic ae);
        req_valid = 1'b1;
        req_vaddr = va;
        req_asid  = as;
        req_ven   = ve;
        req_aen   = ae;
    endtask

    // Hold the request until the model sees it accepted (bounded).
    task automatic push_req(input logic [31:0] va, input logic [8:0] as, input logic ve, input logic ae);
        bit acc;
        acc = 1'b0;
        set_req(va, as, ve, ae);
        for (int k = 0; k < 40 && !acc; k++) begin
            acc = (m_q.size() < DEPTH);
            cycle();
        end
        chk("push_accepted", 64'(acc), 64'(1));
        req_valid = 1'b0;
    endtask

    task automatic clear_log();
        s_vaddr.delete();
        s_qual.delete();
        s_cyc.delete();
    endtask

    initial begin
        int d0;
        bit acc;

        // ---------------- reset values ----------------
        #1 rst_i = 1'b1;
        #6;
        check_all();
        chk("rst_ready", 64'(req_ready_o), 64'(1));
        chk("rst_block", 64'(lu_block_o),  64'(0));
        #5 rst_i = 1'b0;

        // ---------------- single flush ----------------
        set_req(32'h8000_1000, 9'h05, 1'b1, 1'b1);
        cycle();
        req_valid = 1'b0;
        chk("t1_block_c1", 64'(lu_block_o), 64'(1));
        cycle();
        chk("t1_itlb_c2",  64'(flush_itlb_o),          64'(1));
        chk("t1_dtlb_c2",  64'(flush_dtlb_o),          64'(1));
        chk("t1_vaddr_c2", 64'(vaddr_to_be_flushed_o), 64'h8000_1000);
        chk("t1_asid_c2",  64'(asid_to_be_flushed_o),  64'h05);
        chk("t1_qual_c2",  64'({flush_by_vaddr_o, flush_by_asid_o}), 64'h3);
        cycle();
        chk("t1_done_c3", 64'(done_o), 64'(1));
        cycle();
        chk("t1_pend_c4", 64'(pending_o), 64'(0));

        // ---------------- PTW stall ----------------
        ptw_busy = 1'b1;
        push_req(32'h1234_5000, 9'h1a, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("t2_stall_block", 64'(lu_block_o),   64'(1));
            chk("t2_stall_nostb", 64'(flush_itlb_o), 64'(0));
        end
        ptw_busy = 1'b0;
        cycle();
        chk("t2_strobe_after_release", 64'(flush_itlb_o), 64'(1));
        repeat (3) cycle();

        // ---------------- FIFO full ----------------
        clear_log();
        d0 = n_done;
        ptw_busy = 1'b1;
        push_req(32'hA000_0000, 9'h011, 1'b1, 1'b1);
        push_req(32'hB000_0000, 9'h022, 1'b1, 1'b0);
        set_req(32'hC000_0000, 9'h033, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            chk("t3_full_ready", 64'(req_ready_o), 64'(0));
            cycle();
        end
        ptw_busy = 1'b0;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            acc = (m_q.size() < DEPTH);
            cycle();
        end
        chk("t3_third_accepted", 64'(acc), 64'(1));
        req_valid = 1'b0;
        repeat (12) cycle();
        chk("t3_nstrobes", 64'(s_vaddr.size()), 64'(3));
        chk("t3_ndone",    64'(n_done - d0),    64'(3));
        if (s_vaddr.size() == 3) begin
            chk("t3_order0",  64'(s_vaddr[0]), 64'hA000_0000);
            chk("t3_order1",  64'(s_vaddr[1]), 64'hB000_0000);
            chk("t3_order2",  64'(s_vaddr[2]), 64'hC000_0000);
            chk("t3_space01", 64'(s_cyc[1] - s_cyc[0]), 64'(3));
            chk("t3_space12", 64'(s_cyc[2] - s_cyc[1]), 64'(3));
        end

        // ---------------- flush-all coalescing ----------------
        clear_log();
        d0 = n_done;
        ptw_busy = 1'b1;
        push_req(32'h0000_0000, 9'h000, 1'b0, 1'b0);
        push_req(32'h0000_0000, 9'h044, 1'b0, 1'b1);
        ptw_busy = 1'b0;
        repeat (8) cycle();
        chk("t4_nstrobes", 64'(s_vaddr.size()), 64'(1));
        chk("t4_ndone",    64'(n_done - d0),    64'(1));
        if (s_qual.size() != 0) chk("t4_qual", 64'(s_qual[0]), 64'(0));
        chk("t4_empty", 64'(pending_o), 64'(0));

        // ---------------- async reset during BLOCK ----------------
        ptw_busy = 1'b1;
        push_req(32'hD000_0000, 9'h055, 1'b1, 1'b1);
        push_req(32'hE000_0000, 9'h066, 1'b1, 1'b0);
        cycle();
        chk("t5_pre_block", 64'(lu_block_o), 64'(1));
        #2 rst_i = 1'b1;
        m_q.delete();
        m_ph = P_IDLE;
        #1;
        check_all();
        chk("t5_rst_block", 64'(lu_block_o),  64'(0));
        chk("t5_rst_ready", 64'(req_ready_o), 64'(1));
        chk("t5_rst_pend",  64'(pending_o),   64'(0));
        #1 rst_i = 1'b0;
        ptw_busy = 1'b0;
        clear_log();
        repeat (6) cycle();
        chk("t5_no_strobe", 64'(s_vaddr.size()), 64'(0));
        chk("t5_pend",      64'(pending_o),      64'(0));

        // ---------------- push while popping ----------------
        clear_log();
        ptw_busy = 1'b1;
        push_req(32'hF000_1000, 9'h077, 1'b1, 1'b1);
        ptw_busy = 1'b0;
        cycle();
        chk("t6_in_flush", 64'(flush_itlb_o), 64'(1));
        set_req(32'hF000_2000, 9'h088, 1'b1, 1'b0);
        chk("t6_ready_in_flush", 64'(req_ready_o), 64'(1));
        cycle();
        req_valid = 1'b0;
        repeat (6) cycle();
        chk("t6_nstrobes", 64'(s_vaddr.size()), 64'(2));
        if (s_vaddr.size() == 2) chk("t6_second", 64'(s_vaddr[1]), 64'hF000_2000);

        // ---------------- randomized run ----------------
        for (int k = 0; k < 400; k++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_vaddr = 32'($urandom);
            req_asid  = 9'($urandom);
            req_ven   = 1'($urandom_range(0, 1));
            req_aen   = 1'($urandom_range(0, 1));
            ptw_busy  = ($urandom_range(0, 3) == 0);
            cycle();
        end
        req_valid = 1'b0;
        ptw_busy  = 1'b0;
        repeat (12) cycle();
        chk("rand_drained", 64'(pending_o), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
